aes_block_packer: RTL and testbench
===================================

Name: aes_block_packer

Overview:
- Upstream feeder for the iterative AES-128 encryption core in the password-storage datapath.
- Accepts a byte stream (password/record bytes) over a valid/ready handshake and packs it MSB-first into 128-bit plaintext blocks.
- Applies padding to the final block and emits one block at a time, using a start/done handshake with the AES core.
- Holds each block stable until the core reports completion, then resumes accepting bytes.

Parameters:
- PAD_EN, 1, 1 = PKCS#7 padding (adds an extra full pad block when the message is a multiple of 16 bytes); 0 = zero padding, no extra block.
- DONE_TIMEOUT, 0, maximum cycles to wait for aes_done in WAIT; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- byte_in  in  8  input data byte
- byte_valid  in  1  byte_in is valid
- byte_last  in  1  qualifies the final byte of a message (sampled with byte_valid)
- byte_ready  out  1  packer can accept a byte this cycle
- plaintext  out  128  packed block to the AES core; first byte at [127:120], 16th byte at [7:0]
- aes_start  out  1  one-cycle pulse: plaintext valid, begin encryption
- blk_last  out  1  current plaintext is the final block of the message; valid from aes_start until leaving WAIT
- aes_done  in  1  AES core finished the current block (cipher_text valid)
- busy  out  1  high in SEND and WAIT
- err  out  1  sticky timeout flag

Behaviour:
- States: FILL, SEND, WAIT. Reset state is FILL.
- Reset values: plaintext=0, byte count=0, aes_start=0, blk_last=0, pad_pending=0, err=0, timeout counter=0.
- byte_ready = (state==FILL). It is 1 after reset; byte_valid is ignored while reset is high.
- FILL, byte accepted (byte_valid & byte_ready): write byte_in to slot cnt (bits [127-8*cnt -: 8]), then cnt++.
  - cnt reaches 16 without byte_last: next state SEND, blk_last=0, cnt=0.
  - byte_last accepted at slot k (0..15), n=k+1 bytes present:
    - PAD_EN=1, n<16: slots n..15 are written with value 16-n in the same cycle; blk_last=1.
    - PAD_EN=1, n=16: blk_last=0 and pad_pending=1.
    - PAD_EN=0: slots n..15 are written with 0x00; blk_last=1.
    - In all cases next state is SEND and cnt=0.
- SEND (exactly one cycle): aes_start=1; next state WAIT; timeout counter cleared. Latency from the last accepted byte to aes_start is 1 cycle.
- WAIT: plaintext and blk_last are held stable.
  - On aes_done with pad_pending=1: plaintext <= 0x10 in all 16 bytes, blk_last=1, pad_pending=0, next state SEND.
  - On aes_done with pad_pending=0: next state FILL, blk_last=0. byte_ready rises the cycle after aes_done.
- Timeout (DONE_TIMEOUT>0): the counter increments each WAIT cycle without aes_done.
  - When it reaches DONE_TIMEOUT: err=1 (sticky until reset), pad_pending=0, blk_last=0, cnt=0, next state FILL.
  - aes_done in the same cycle as the terminal count wins; no error is raised.
- aes_done outside WAIT is ignored, including in the SEND cycle.
- Zero-length messages cannot occur, since byte_last always accompanies a byte. byte_last without byte_valid is ignored.
- Asynchronous reset mid-block or mid-WAIT discards all partial data; aes_start deasserts immediately.
- The packer never issues a second aes_start before aes_done (or timeout) for the previous block.

Test Plan:
- Reset, then bytes 50 61 73 73 (last on 4th) -> one cycle later aes_start=1, blk_last=1, plaintext=0x506173730c0c0c0c0c0c0c0c0c0c0c0c; byte_ready=0 until the cycle after aes_done.
- 16 bytes 00..0f, last on 0x0f, PAD_EN=1 -> block 0x000102…0f with blk_last=0; after aes_done, second aes_start with plaintext all 0x10 and blk_last=1; after the second aes_done, byte_ready=1.
- 20 bytes 0x41 with PAD_EN=0, last on 20th -> first block all 0x41 with blk_last=0; second block 0x41414141 followed by 24 zero hex digits, blk_last=1.
- byte_valid toggled every other cycle, aes_done asserted during SEND and FILL -> packing unaffected, spurious aes_done ignored, exactly one aes_start per block.
- DONE_TIMEOUT=8, aes_done never asserted -> 8 cycles after entering WAIT: err=1, state FILL, byte_ready=1. A new message is then processed normally while err stays 1.
- Async reset asserted mid-WAIT with pad_pending=1 -> outputs return to reset values immediately; the next message starts at slot 0 and no pad block is emitted.

Source files
------------

// File: rtl/aes_block_packer_if.sv
// Byte-stream and AES-core handshake bundle for the block packer.
// The slave modport is the packer's view; the master modport is the feeder/core side.
interface aes_block_packer_if;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_last;
    logic         byte_ready;
    logic [127:0] plaintext;
    logic         aes_start;
    logic         blk_last;
    logic         aes_done;
    logic         busy;
    logic         err;

    modport master (
        output byte_in, byte_valid, byte_last, aes_done,
        input  byte_ready, plaintext, aes_start, blk_last, busy, err
    );

    modport slave (
        input  byte_in, byte_valid, byte_last, aes_done,
        output byte_ready, plaintext, aes_start, blk_last, busy, err
    );
endinterface

// File: rtl/aes_block_packer.sv
// Packs a byte stream MSB-first into padded 128-bit blocks and hands them one at a time
// to an iterative AES-128 core, holding each block until the core reports completion.
module aes_block_packer #(
    parameter bit PAD_EN       = 1'b1,
    parameter int DONE_TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               reset,
    aes_block_packer_if.slave  bus
);
    localparam int TMO_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

    typedef enum logic [1:0] {FILL, SEND, WAIT} state_t;

    state_t         state_q;
    logic [127:0]   plaintext_q;
    logic [127:0]   plaintext_d;
    logic [3:0]     cnt_q;
    logic           aesStart_q;
    logic           blkLast_q;
    logic           padPending_q;
    logic           err_q;
    logic [TMO_W-1:0] tmo_q;
    logic [7:0]     padByte;

    // PKCS#7 pad value is the number of missing bytes, 16-n with n = cnt+1.
    assign padByte = PAD_EN ? {4'h0, 4'hF - cnt_q} : 8'h00;

    // Block image after accepting the current byte, including same-cycle padding on the last byte.
    always_comb begin
        plaintext_d = plaintext_q;
        for (int i = 0; i < 16; i++) begin
            if (4'(i) == cnt_q) begin
                plaintext_d[127-8*i -: 8] = bus.byte_in;
            end else if (bus.byte_last && (4'(i) > cnt_q)) begin
                plaintext_d[127-8*i -: 8] = padByte;
            end
        end
    end

    // Packer state machine; aes_start is registered so it is high exactly for the SEND cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            plaintext_q  <= '0;
            cnt_q        <= '0;
            aesStart_q   <= 1'b0;
            blkLast_q    <= 1'b0;
            padPending_q <= 1'b0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
        end else begin
            aesStart_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (bus.byte_valid) begin
                        plaintext_q <= plaintext_d;
                        if (bus.byte_last) begin
                            cnt_q      <= '0;
                            state_q    <= SEND;
                            aesStart_q <= 1'b1;
                            if (PAD_EN && (cnt_q == 4'd15)) begin
                                blkLast_q    <= 1'b0;
                                padPending_q <= 1'b1;
                            end else begin
                                blkLast_q <= 1'b1;
                            end
                        end else if (cnt_q == 4'd15) begin
                            cnt_q      <= '0;
                            blkLast_q  <= 1'b0;
                            state_q    <= SEND;
                            aesStart_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                SEND: begin
                    state_q <= WAIT;
                    tmo_q   <= '0;
                end
                WAIT: begin
                    if (bus.aes_done) begin
                        if (padPending_q) begin
                            plaintext_q  <= {16{8'h10}};
                            blkLast_q    <= 1'b1;
                            padPending_q <= 1'b0;
                            state_q      <= SEND;
                            aesStart_q   <= 1'b1;
                        end else begin
                            blkLast_q <= 1'b0;
                            state_q   <= FILL;
                        end
                    end else if (DONE_TIMEOUT > 0) begin
                        // A stalled core abandons the message rather than locking the datapath.
                        if (tmo_q == TMO_W'(DONE_TIMEOUT - 1)) begin
                            err_q        <= 1'b1;
                            padPending_q <= 1'b0;
                            blkLast_q    <= 1'b0;
                            cnt_q        <= '0;
                            state_q      <= FILL;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.byte_ready = (state_q == FILL);
    assign bus.busy       = (state_q != FILL);
    assign bus.plaintext  = plaintext_q;
    assign bus.aes_start  = aesStart_q;
    assign bus.blk_last   = blkLast_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_aes_block_packer.sv
// Directed bench: unit A uses PKCS#7 padding with an 8-cycle done timeout,
// unit B uses zero padding with the timeout disabled.
module tb_aes_block_packer;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    aes_block_packer_if ifA ();
    aes_block_packer_if ifB ();

    aes_block_packer #(.PAD_EN(1'b1), .DONE_TIMEOUT(8)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (ifA.slave)
    );

    aes_block_packer #(.PAD_EN(1'b0), .DONE_TIMEOUT(0)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (ifB.slave)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendA(input logic [7:0] b, input logic last);
        ifA.byte_in = b; ifA.byte_valid = 1'b1; ifA.byte_last = last;
        tick(1);
        ifA.byte_valid = 1'b0; ifA.byte_last = 1'b0;
    endtask

    task automatic sendB(input logic [7:0] b, input logic last);
        ifB.byte_in = b; ifB.byte_valid = 1'b1; ifB.byte_last = last;
        tick(1);
        ifB.byte_valid = 1'b0; ifB.byte_last = 1'b0;
    endtask

    task automatic doneA();
        ifA.aes_done = 1'b1;
        tick(1);
        ifA.aes_done = 1'b0;
    endtask

    task automatic doneB();
        ifB.aes_done = 1'b1;
        tick(1);
        ifB.aes_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifA.byte_in = 8'hff; ifA.byte_valid = 1'b1; ifA.byte_last = 1'b1;
        tick(2);
        vectors++; if (ifA.byte_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %0b want 1", ifA.byte_ready); end
        vectors++; if (ifA.plaintext !== 128'h0) begin miscompares++; $display("[TB] FAIL reset_pt: got %h want 0", ifA.plaintext); end
        vectors++; if ({ifA.aes_start, ifA.blk_last, ifA.busy, ifA.err} !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_flags: got %b want 0000", {ifA.aes_start, ifA.blk_last, ifA.busy, ifA.err}); end
        vectors++; if ({ifB.byte_ready, ifB.aes_start, ifB.err} !== 3'b100) begin miscompares++; $display("[TB] FAIL reset_B: got %b want 100", {ifB.byte_ready, ifB.aes_start, ifB.err}); end
        ifA.byte_valid = 1'b0; ifA.byte_last = 1'b0;
        #2 reset = 1'b0;
        tick(1);
        vectors++; if (ifA.plaintext !== 128'h0) begin miscompares++; $display("[TB] FAIL reset_ignore_valid: got %h want 0", ifA.plaintext); end
    endtask

    task automatic test_short_pkcs();
        sendA(8'h50, 1'b0); sendA(8'h61, 1'b0); sendA(8'h73, 1'b0); sendA(8'h73, 1'b1);
        vectors++; if (ifA.aes_start !== 1'b1) begin miscompares++; $display("[TB] FAIL short_start: got %0b want 1", ifA.aes_start); end
        vectors++; if (ifA.blk_last !== 1'b1) begin miscompares++; $display("[TB] FAIL short_last: got %0b want 1", ifA.blk_last); end
        vectors++; if (ifA.plaintext !== 128'h506173730c0c0c0c0c0c0c0c0c0c0c0c) begin miscompares++; $display("[TB] FAIL short_pt: got %h want 506173730c0c0c0c0c0c0c0c0c0c0c0c", ifA.plaintext); end
        vectors++; if ({ifA.byte_ready, ifA.busy} !== 2'b01) begin miscompares++; $display("[TB] FAIL short_busy: got %b want 01", {ifA.byte_ready, ifA.busy}); end
        tick(1);
        vectors++; if ({ifA.aes_start, ifA.byte_ready} !== 2'b00) begin miscompares++; $display("[TB] FAIL short_wait: got %b want 00", {ifA.aes_start, ifA.byte_ready}); end
        tick(2);
        vectors++; if (ifA.byte_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL short_hold_ready: got %0b want 0", ifA.byte_ready); end
        doneA();
        vectors++; if ({ifA.byte_ready, ifA.blk_last, ifA.busy} !== 3'b100) begin miscompares++; $display("[TB] FAIL short_release: got %b want 100", {ifA.byte_ready, ifA.blk_last, ifA.busy}); end
    endtask

    task automatic test_full_block_pad();
        for (int i = 0; i < 16; i++) sendA(8'(i), i == 15);
        vectors++; if ({ifA.aes_start, ifA.blk_last} !== 2'b10) begin miscompares++; $display("[TB] FAIL full_first: got %b want 10", {ifA.aes_start, ifA.blk_last}); end
        vectors++; if (ifA.plaintext !== 128'h000102030405060708090a0b0c0d0e0f) begin miscompares++; $display("[TB] FAIL full_pt: got %h want 000102030405060708090a0b0c0d0e0f", ifA.plaintext); end
        tick(1);
        doneA();
        vectors++; if ({ifA.aes_start, ifA.blk_last, ifA.byte_ready} !== 3'b110) begin miscompares++; $display("[TB] FAIL full_padblk: got %b want 110", {ifA.aes_start, ifA.blk_last, ifA.byte_ready}); end
        vectors++; if (ifA.plaintext !== {16{8'h10}}) begin miscompares++; $display("[TB] FAIL full_padpt: got %h want all 10", ifA.plaintext); end
        tick(1);
        vectors++; if ({ifA.aes_start, ifA.blk_last, ifA.byte_ready} !== 3'b010) begin miscompares++; $display("[TB] FAIL full_padwait: got %b want 010", {ifA.aes_start, ifA.blk_last, ifA.byte_ready}); end
        doneA();
        vectors++; if ({ifA.byte_ready, ifA.aes_start, ifA.blk_last} !== 3'b100) begin miscompares++; $display("[TB] FAIL full_release: got %b want 100", {ifA.byte_ready, ifA.aes_start, ifA.blk_last}); end
    endtask

    task automatic test_zero_pad();
        for (int i = 0; i < 16; i++) sendB(8'h41, 1'b0);
        vectors++; if ({ifB.aes_start, ifB.blk_last} !== 2'b10) begin miscompares++; $display("[TB] FAIL zero_first: got %b want 10", {ifB.aes_start, ifB.blk_last}); end
        vectors++; if (ifB.plaintext !== {16{8'h41}}) begin miscompares++; $display("[TB] FAIL zero_first_pt: got %h want all 41", ifB.plaintext); end
        tick(20);
        vectors++; if ({ifB.err, ifB.byte_ready, ifB.busy} !== 3'b001) begin miscompares++; $display("[TB] FAIL zero_no_timeout: got %b want 001", {ifB.err, ifB.byte_ready, ifB.busy}); end
        doneB();
        for (int i = 0; i < 4; i++) sendB(8'h41, i == 3);
        vectors++; if ({ifB.aes_start, ifB.blk_last} !== 2'b11) begin miscompares++; $display("[TB] FAIL zero_second: got %b want 11", {ifB.aes_start, ifB.blk_last}); end
        vectors++; if (ifB.plaintext !== {32'h41414141, 96'h0}) begin miscompares++; $display("[TB] FAIL zero_second_pt: got %h want 41414141 then zeros", ifB.plaintext); end
        tick(1);
        doneB();
        vectors++; if ({ifB.byte_ready, ifB.blk_last} !== 2'b10) begin miscompares++; $display("[TB] FAIL zero_release: got %b want 10", {ifB.byte_ready, ifB.blk_last}); end
    endtask

    task automatic test_gapped_spurious();
        logic [7:0] msg [5] = '{8'hde, 8'had, 8'hbe, 8'hef, 8'h01};
        int starts = 0;
        for (int i = 0; i < 5; i++) begin
            ifA.byte_in = msg[i]; ifA.byte_valid = 1'b1; ifA.byte_last = (i == 4); ifA.aes_done = 1'b0;
            tick(1);
            starts += int'(ifA.aes_start);
            if (i < 4) begin
                ifA.byte_valid = 1'b0; ifA.byte_last = 1'b1; ifA.aes_done = 1'b1; ifA.byte_in = 8'hee;
                tick(1);
                starts += int'(ifA.aes_start);
            end
        end
        ifA.byte_valid = 1'b0; ifA.byte_last = 1'b0;
        vectors++; if (ifA.plaintext !== 128'hdeadbeef010b0b0b0b0b0b0b0b0b0b0b) begin miscompares++; $display("[TB] FAIL gap_pt: got %h want deadbeef010b0b0b0b0b0b0b0b0b0b0b", ifA.plaintext); end
        ifA.aes_done = 1'b1;
        tick(1);
        ifA.aes_done = 1'b0;
        starts += int'(ifA.aes_start);
        vectors++; if ({ifA.busy, ifA.byte_ready} !== 2'b10) begin miscompares++; $display("[TB] FAIL gap_send_done_ignored: got %b want 10", {ifA.busy, ifA.byte_ready}); end
        for (int i = 0; i < 3; i++) begin
            tick(1);
            starts += int'(ifA.aes_start);
        end
        doneA();
        vectors++; if (starts !== 1) begin miscompares++; $display("[TB] FAIL gap_start_count: got %0d want 1", starts); end
        vectors++; if (ifA.byte_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL gap_release: got %0b want 1", ifA.byte_ready); end
    endtask

    task automatic test_timeout();
        sendA(8'h7e, 1'b1);
        vectors++; if (ifA.plaintext !== {8'h7e, {15{8'h0f}}}) begin miscompares++; $display("[TB] FAIL tmo_pt: got %h want 7e then 0f", ifA.plaintext); end
        tick(1);
        tick(7);
        vectors++; if ({ifA.err, ifA.byte_ready} !== 2'b00) begin miscompares++; $display("[TB] FAIL tmo_early: got %b want 00", {ifA.err, ifA.byte_ready}); end
        tick(1);
        vectors++; if ({ifA.err, ifA.byte_ready, ifA.busy, ifA.blk_last} !== 4'b1100) begin miscompares++; $display("[TB] FAIL tmo_fire: got %b want 1100", {ifA.err, ifA.byte_ready, ifA.busy, ifA.blk_last}); end
        sendA(8'h01, 1'b0); sendA(8'h02, 1'b0); sendA(8'h03, 1'b1);
        vectors++; if ({ifA.aes_start, ifA.blk_last, ifA.err} !== 3'b111) begin miscompares++; $display("[TB] FAIL tmo_next_start: got %b want 111", {ifA.aes_start, ifA.blk_last, ifA.err}); end
        vectors++; if (ifA.plaintext !== {24'h010203, {13{8'h0d}}}) begin miscompares++; $display("[TB] FAIL tmo_next_pt: got %h want 010203 then 0d", ifA.plaintext); end
        tick(1);
        doneA();
        vectors++; if ({ifA.byte_ready, ifA.err} !== 2'b11) begin miscompares++; $display("[TB] FAIL tmo_sticky: got %b want 11", {ifA.byte_ready, ifA.err}); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 16; i++) sendA(8'h20 + 8'(i), i == 15);
        vectors++; if ({ifA.aes_start, ifA.blk_last} !== 2'b10) begin miscompares++; $display("[TB] FAIL ar_full_block: got %b want 10", {ifA.aes_start, ifA.blk_last}); end
        tick(1);
        #2 reset = 1'b1;
        #1;
        vectors++; if ({ifA.byte_ready, ifA.busy, ifA.aes_start, ifA.blk_last, ifA.err} !== 5'b10000) begin miscompares++; $display("[TB] FAIL ar_immediate: got %b want 10000", {ifA.byte_ready, ifA.busy, ifA.aes_start, ifA.blk_last, ifA.err}); end
        vectors++; if (ifA.plaintext !== 128'h0) begin miscompares++; $display("[TB] FAIL ar_pt: got %h want 0", ifA.plaintext); end
        #1 reset = 1'b0;
        tick(1);
        sendA(8'haa, 1'b0); sendA(8'hbb, 1'b1);
        vectors++; if (ifA.plaintext !== {16'haabb, {14{8'h0e}}}) begin miscompares++; $display("[TB] FAIL ar_next_pt: got %h want aabb then 0e", ifA.plaintext); end
        tick(1);
        doneA();
        vectors++; if ({ifA.byte_ready, ifA.aes_start} !== 2'b10) begin miscompares++; $display("[TB] FAIL ar_no_padblk: got %b want 10", {ifA.byte_ready, ifA.aes_start}); end
    endtask

    task automatic test_done_at_terminal();
        sendA(8'h55, 1'b1);
        tick(1);
        tick(7);
        doneA();
        vectors++; if ({ifA.err, ifA.byte_ready} !== 2'b01) begin miscompares++; $display("[TB] FAIL term_done_wins: got %b want 01", {ifA.err, ifA.byte_ready}); end
    endtask

    // Scenario sequence; unit B idles in FILL while unit A is exercised and vice versa.
    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1;
        ifA.byte_in = 8'h00; ifA.byte_valid = 1'b0; ifA.byte_last = 1'b0; ifA.aes_done = 1'b0;
        ifB.byte_in = 8'h00; ifB.byte_valid = 1'b0; ifB.byte_last = 1'b0; ifB.aes_done = 1'b0;
        test_reset();
        test_short_pkcs();
        test_full_block_pad();
        test_zero_pad();
        test_gapped_spurious();
        test_timeout();
        test_async_reset();
        test_done_at_terminal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
